wb_dma_ch_rf_bank: RTL and testbench
====================================

# wb_dma_ch_rf_bank

Parametrised register-file bank holding NUM_CH DMA channel register sets behind one Wishbone register-file port, replacing per-channel hand-instantiated register files. It decodes host reads and writes, takes DMA-engine write-back for the channel the arbiter selects (ch_sel), and keeps sticky per-channel interrupt sources with masks. It also supports auto-restart from shadow copies and a compile-time channel-present mask. It sits between the Wishbone slave interface and the DMA engine/arbiter.

## Interface
Parameters:
- NUM_CH, 8: number of channel slots, 1..31.
- TXSZ_W, 12: transfer-size field width, 4..16.
- CH_PRESENT, all ones: NUM_CH-bit mask; absent slots read 0, ignore writes, and drive all outputs 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wb_rf_adr  in  8  register address: [7:3] channel, [2:0] register offset
- wb_rf_din  in  32  write data
- wb_rf_we / wb_rf_re  in  1  write / read strobe, single cycle
- wb_rf_dout  out  32  read data, registered
- ch_sel  in  5  channel currently owned by the engine
- de_csr_we, de_txsz_we, de_adr0_we, de_adr1_we  in  1  engine write-back strobes, applied to ch_sel
- de_txsz  in  TXSZ_W; de_adr0, de_adr1  in  32  engine write-back data
- dma_done, dma_err, chunk_done  in  1  engine events for ch_sel, single-cycle pulses
- sel_csr, sel_txsz, sel_adr0, sel_adr1, sel_am0, sel_am1, sel_ptr  out  32  registers of ch_sel, combinational mux
- ch_en  out  NUM_CH  CSR.EN per channel
- ch_stop  out  NUM_CH  one-cycle stop pulse per channel
- intt  out  NUM_CH  per-channel interrupt
- inta  out  1  OR of intt

## Operation
- Register offsets: 0 CSR, 1 TXSZ, 2 ADR0, 3 AM0, 4 ADR1, 5 AM1, 6 PTR, 7 SWPTR. Channel index is wb_rf_adr[7:3]. An index >= NUM_CH, or an index whose CH_PRESENT bit is 0, reads 0 and ignores writes.
- CSR bits:
  - [0] EN
  - [1] ARS (auto-restart)
  - [11] BUSY (RO)
  - [12] DONE (RO)
  - [13] ERR (RO)
  - [14] STOP: write 1 produces a ch_stop pulse; the bit reads 0
  - [19:17] interrupt mask {chunk, done, err}
  - [22:20] interrupt sources (RO, cleared on CSR read)
  - All other bits read 0.
- TXSZ uses [TXSZ_W-1:0]. Upper bits read 0.
- A host write to TXSZ, ADR0 or ADR1 also loads that register's shadow copy.
- Engine events (apply to ch_sel only):
  - de_*_we updates the live register.
  - Setting EN sets BUSY.
  - dma_done: BUSY→0, DONE→1, sets the done source. If ARS=1, TXSZ/ADR0/ADR1 reload from the shadows and EN stays 1. If ARS=0, EN→0.
  - dma_err: BUSY→0, ERR→1, EN→0, sets the err source. ARS is ignored.
  - chunk_done: sets the chunk source.
- A host write of EN=1 clears DONE and ERR.
- intt[i] = |(src[i] & mask[i]).

## Timing
- Reset: every register, shadow and source is 0; wb_rf_dout, ch_en, ch_stop, intt and inta are 0.
- Writes are visible on sel_*/ch_en the cycle after the strobe.
- Read latency is 1: wb_rf_dout is valid the cycle after wb_rf_re and holds until the next read.
- Same channel, same register, host write and engine write in the same cycle: the engine wins; the host data is dropped and the shadow is still loaded.
- Source set and CSR read-clear in the same cycle: the source stays set, and the read returns the pre-set value.
- dma_done and dma_err in the same cycle: err takes priority, but both sources are set.
- ch_stop is high for exactly one cycle, the cycle after the write.
- rst asserted mid-transfer: all state clears on the next edge and no interrupt is produced.

## Structure
- Package wb_dma_rf_pkg: register offset constants, CSR bit-position constants, and the source-index enum {SRC_ERR, SRC_DONE, SRC_CHUNK}.
- Sub-module wb_dma_ch_rf_slot: one channel's registers, shadows, sources and status. Instantiated NUM_CH times by generate; absent slots are tied off.
- The bank holds the address decode, the read mux/register, the sel_* mux and the inta OR.

## Test plan
- Reset, then read all 8 offsets of channel 0 → all 0x00000000; intt=0.
- Write ADR0 = 0x1000_0000 to channel 3, set ch_sel=3, read back → sel_adr0 equals the value one cycle after the write; read returns the same value at latency 1.
- Channel 2: CSR = EN|mask_done, ch_sel=2, pulse dma_done → intt[2]=1 and inta=1. CSR read returns DONE=1, EN=0, src=3'b010. The next read returns src=0 and intt[2]=0.
- ARS=1, TXSZ=0x040, engine writes TXSZ=0x000, then dma_done → TXSZ reads 0x040 and EN stays 1.
- Host writes TXSZ=0x111 while de_txsz_we=1 with 0x222 on the same channel → TXSZ=0x222 and the shadow holds 0x111. Address channel index 31 with NUM_CH=8 → read 0, no state change.
- CH_PRESENT=8'hFE: write CSR EN=1 to channel 0 → ch_en[0] stays 0 and the read returns 0.

Source files
------------

// File: rtl/wb_dma_rf_pkg.sv
// Shared definitions for the DMA channel register-file bank: register offsets,
// CSR bit positions, interrupt-source indices and the engine event payload.
package wb_dma_rf_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 3;

  localparam logic [2:0] OFF_CSR   = 3'd0;
  localparam logic [2:0] OFF_TXSZ  = 3'd1;
  localparam logic [2:0] OFF_ADR0  = 3'd2;
  localparam logic [2:0] OFF_AM0   = 3'd3;
  localparam logic [2:0] OFF_ADR1  = 3'd4;
  localparam logic [2:0] OFF_AM1   = 3'd5;
  localparam logic [2:0] OFF_PTR   = 3'd6;
  localparam logic [2:0] OFF_SWPTR = 3'd7;

  localparam int unsigned CSR_EN      = 0;
  localparam int unsigned CSR_ARS     = 1;
  localparam int unsigned CSR_BUSY    = 11;
  localparam int unsigned CSR_DONE    = 12;
  localparam int unsigned CSR_ERR     = 13;
  localparam int unsigned CSR_STOP    = 14;
  localparam int unsigned CSR_MASK_LO = 17;
  localparam int unsigned CSR_SRC_LO  = 20;

  typedef enum logic [1:0] {
    SRC_ERR   = 2'd0,
    SRC_DONE  = 2'd1,
    SRC_CHUNK = 2'd2
  } src_e;

  // Engine strobes/events, already qualified to the channel the arbiter selected
  typedef struct packed {
    logic csr_we;
    logic txsz_we;
    logic adr0_we;
    logic adr1_we;
    logic done;
    logic err;
    logic chunk;
  } de_ev_t;

  function automatic logic [DATA_W-1:0] csr_pack(
    input logic             en,
    input logic             ars,
    input logic             busy,
    input logic             done,
    input logic             err,
    input logic [SRC_W-1:0] mask,
    input logic [SRC_W-1:0] src
  );
    logic [DATA_W-1:0] v_word;
    v_word                      = '0;
    v_word[CSR_EN]              = en;
    v_word[CSR_ARS]             = ars;
    v_word[CSR_BUSY]            = busy;
    v_word[CSR_DONE]            = done;
    v_word[CSR_ERR]             = err;
    v_word[CSR_MASK_LO +: SRC_W] = mask;
    v_word[CSR_SRC_LO +: SRC_W]  = src;
    return v_word;
  endfunction

endpackage

// File: rtl/wb_dma_ch_rf_slot.sv
// One DMA channel: live registers, restart shadows, status bits and sticky
// interrupt sources. Engine updates beat host writes to the same register.
module wb_dma_ch_rf_slot
  import wb_dma_rf_pkg::*;
#(
  parameter int unsigned TXSZ_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic              i_rd_csr,
  input  logic [2:0]        i_off,
  input  logic [31:0]       i_din,
  input  de_ev_t            i_ev,
  input  logic [TXSZ_W-1:0] i_de_txsz,
  input  logic [31:0]       i_de_adr0,
  input  logic [31:0]       i_de_adr1,
  output logic [31:0]       o_rdata_c,
  output logic [31:0]       o_csr,
  output logic [31:0]       o_txsz,
  output logic [31:0]       o_adr0,
  output logic [31:0]       o_am0,
  output logic [31:0]       o_adr1,
  output logic [31:0]       o_am1,
  output logic [31:0]       o_ptr,
  output logic              o_en,
  output logic              o_stop,
  output logic              o_intt,
  output logic              o_intt_nxt_c
);

  logic              r_en, r_ars, r_busy, r_done, r_err, r_stop, r_intt;
  logic [SRC_W-1:0]  r_mask, r_src;
  logic [TXSZ_W-1:0] r_txsz, r_txsz_sh;
  logic [31:0]       r_adr0, r_adr1, r_adr0_sh, r_adr1_sh;
  logic [31:0]       r_am0, r_am1, r_ptr, r_swptr;

  logic              w_en_n, w_ars_n, w_busy_n, w_done_n, w_err_n;
  logic [SRC_W-1:0]  w_mask_n, w_src_n;
  logic [TXSZ_W-1:0] w_txsz_n;
  logic [31:0]       w_adr0_n, w_adr1_n;
  logic              w_wr_csr, w_wr_txsz, w_wr_adr0, w_wr_adr1, w_reload;

  assign w_wr_csr  = i_wr && (i_off == OFF_CSR);
  assign w_wr_txsz = i_wr && (i_off == OFF_TXSZ);
  assign w_wr_adr0 = i_wr && (i_off == OFF_ADR0);
  assign w_wr_adr1 = i_wr && (i_off == OFF_ADR1);
  assign w_reload  = i_ev.done && r_ars;

  // Host effects first, engine events layered on top so they take precedence
  always_comb begin
    w_en_n   = r_en;
    w_ars_n  = r_ars;
    w_busy_n = r_busy;
    w_done_n = r_done;
    w_err_n  = r_err;
    w_mask_n = r_mask;
    w_src_n  = i_rd_csr ? '0 : r_src;
    w_txsz_n = r_txsz;
    w_adr0_n = r_adr0;
    w_adr1_n = r_adr1;

    if (w_wr_csr) begin
      w_en_n   = i_din[CSR_EN];
      w_ars_n  = i_din[CSR_ARS];
      w_mask_n = i_din[CSR_MASK_LO +: SRC_W];
      if (i_din[CSR_EN]) begin
        w_busy_n = 1'b1;
        w_done_n = 1'b0;
        w_err_n  = 1'b0;
      end
    end
    if (w_wr_txsz) w_txsz_n = i_din[TXSZ_W-1:0];
    if (w_wr_adr0) w_adr0_n = i_din;
    if (w_wr_adr1) w_adr1_n = i_din;

    if (i_ev.csr_we)  w_busy_n = 1'b1;
    if (i_ev.txsz_we) w_txsz_n = i_de_txsz;
    if (i_ev.adr0_we) w_adr0_n = i_de_adr0;
    if (i_ev.adr1_we) w_adr1_n = i_de_adr1;

    if (i_ev.done) begin
      w_busy_n                = 1'b0;
      w_done_n                = 1'b1;
      w_src_n[int'(SRC_DONE)] = 1'b1;
      if (!r_ars) w_en_n = 1'b0;
    end
    if (w_reload) begin
      w_txsz_n = r_txsz_sh;
      w_adr0_n = r_adr0_sh;
      w_adr1_n = r_adr1_sh;
    end
    if (i_ev.err) begin
      w_busy_n               = 1'b0;
      w_err_n                = 1'b1;
      w_en_n                 = 1'b0;
      w_src_n[int'(SRC_ERR)] = 1'b1;
    end
    if (i_ev.chunk) w_src_n[int'(SRC_CHUNK)] = 1'b1;
  end

  assign o_intt_nxt_c = |(w_src_n & w_mask_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_ars     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_stop    <= 1'b0;
      r_intt    <= 1'b0;
      r_mask    <= '0;
      r_src     <= '0;
      r_txsz    <= '0;
      r_txsz_sh <= '0;
      r_adr0    <= '0;
      r_adr1    <= '0;
      r_adr0_sh <= '0;
      r_adr1_sh <= '0;
      r_am0     <= '0;
      r_am1     <= '0;
      r_ptr     <= '0;
      r_swptr   <= '0;
    end else begin
      r_en   <= w_en_n;
      r_ars  <= w_ars_n;
      r_busy <= w_busy_n;
      r_done <= w_done_n;
      r_err  <= w_err_n;
      r_mask <= w_mask_n;
      r_src  <= w_src_n;
      r_stop <= w_wr_csr && i_din[CSR_STOP];
      r_intt <= o_intt_nxt_c;
      r_txsz <= w_txsz_n;
      r_adr0 <= w_adr0_n;
      r_adr1 <= w_adr1_n;
      // Shadows track host data even when the engine wins the live register
      if (w_wr_txsz) r_txsz_sh <= i_din[TXSZ_W-1:0];
      if (w_wr_adr0) r_adr0_sh <= i_din;
      if (w_wr_adr1) r_adr1_sh <= i_din;
      if (i_wr && (i_off == OFF_AM0))   r_am0   <= i_din;
      if (i_wr && (i_off == OFF_AM1))   r_am1   <= i_din;
      if (i_wr && (i_off == OFF_PTR))   r_ptr   <= i_din;
      if (i_wr && (i_off == OFF_SWPTR)) r_swptr <= i_din;
    end
  end

  assign o_csr  = csr_pack(r_en, r_ars, r_busy, r_done, r_err, r_mask, r_src);
  assign o_txsz = 32'(r_txsz);
  assign o_adr0 = r_adr0;
  assign o_am0  = r_am0;
  assign o_adr1 = r_adr1;
  assign o_am1  = r_am1;
  assign o_ptr  = r_ptr;
  assign o_en   = r_en;
  assign o_stop = r_stop;
  assign o_intt = r_intt;

  always_comb begin
    o_rdata_c = '0;
    case (i_off)
      OFF_CSR:   o_rdata_c = o_csr;
      OFF_TXSZ:  o_rdata_c = o_txsz;
      OFF_ADR0:  o_rdata_c = r_adr0;
      OFF_AM0:   o_rdata_c = r_am0;
      OFF_ADR1:  o_rdata_c = r_adr1;
      OFF_AM1:   o_rdata_c = r_am1;
      OFF_PTR:   o_rdata_c = r_ptr;
      OFF_SWPTR: o_rdata_c = r_swptr;
      default:   o_rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/wb_dma_ch_rf_bank.sv
// Bank of NUM_CH channel register files behind one Wishbone register port,
// with engine write-back steered to ch_sel and a combined interrupt.
module wb_dma_ch_rf_bank
  import wb_dma_rf_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 8,
  parameter int unsigned       TXSZ_W     = 12,
  parameter logic [NUM_CH-1:0] CH_PRESENT = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wb_rf_adr,
  input  logic [31:0]       wb_rf_din,
  input  logic              wb_rf_we,
  input  logic              wb_rf_re,
  output logic [31:0]       wb_rf_dout,
  input  logic [4:0]        ch_sel,
  input  logic              de_csr_we,
  input  logic              de_txsz_we,
  input  logic              de_adr0_we,
  input  logic              de_adr1_we,
  input  logic [TXSZ_W-1:0] de_txsz,
  input  logic [31:0]       de_adr0,
  input  logic [31:0]       de_adr1,
  input  logic              dma_done,
  input  logic              dma_err,
  input  logic              chunk_done,
  output logic [31:0]       sel_csr,
  output logic [31:0]       sel_txsz,
  output logic [31:0]       sel_adr0,
  output logic [31:0]       sel_adr1,
  output logic [31:0]       sel_am0,
  output logic [31:0]       sel_am1,
  output logic [31:0]       sel_ptr,
  output logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ch_stop,
  output logic [NUM_CH-1:0] intt,
  output logic              inta
);

  logic [4:0]        w_ch;
  logic [2:0]        w_off;
  logic [NUM_CH-1:0] w_hit, w_eng, w_intt_nxt;
  logic [31:0]       w_rdata [NUM_CH];
  logic [31:0]       w_csr   [NUM_CH];
  logic [31:0]       w_txsz  [NUM_CH];
  logic [31:0]       w_adr0  [NUM_CH];
  logic [31:0]       w_adr1  [NUM_CH];
  logic [31:0]       w_am0   [NUM_CH];
  logic [31:0]       w_am1   [NUM_CH];
  logic [31:0]       w_ptr   [NUM_CH];
  logic [31:0]       w_rd_sel;
  logic [31:0]       r_dout;
  logic              r_inta;
  de_ev_t            w_ev;

  assign w_ch  = wb_rf_adr[7:3];
  assign w_off = wb_rf_adr[2:0];
  assign w_ev  = '{csr_we: de_csr_we, txsz_we: de_txsz_we, adr0_we: de_adr0_we,
                   adr1_we: de_adr1_we, done: dma_done, err: dma_err, chunk: chunk_done};

  // Absent slots are tied to zero so they read 0 and never interrupt
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_hit[i] = (w_ch == 5'(i));
    assign w_eng[i] = (ch_sel == 5'(i));
    if (CH_PRESENT[i]) begin : g_on
      wb_dma_ch_rf_slot #(.TXSZ_W(TXSZ_W)) u_slot (
        .clk          (clk),
        .rst          (rst),
        .i_wr         (wb_rf_we && w_hit[i]),
        .i_rd_csr     (wb_rf_re && w_hit[i] && (w_off == OFF_CSR)),
        .i_off        (w_off),
        .i_din        (wb_rf_din),
        .i_ev         (w_eng[i] ? w_ev : '0),
        .i_de_txsz    (de_txsz),
        .i_de_adr0    (de_adr0),
        .i_de_adr1    (de_adr1),
        .o_rdata_c    (w_rdata[i]),
        .o_csr        (w_csr[i]),
        .o_txsz       (w_txsz[i]),
        .o_adr0       (w_adr0[i]),
        .o_am0        (w_am0[i]),
        .o_adr1       (w_adr1[i]),
        .o_am1        (w_am1[i]),
        .o_ptr        (w_ptr[i]),
        .o_en         (ch_en[i]),
        .o_stop       (ch_stop[i]),
        .o_intt       (intt[i]),
        .o_intt_nxt_c (w_intt_nxt[i])
      );
    end else begin : g_off
      assign w_rdata[i]    = '0;
      assign w_csr[i]      = '0;
      assign w_txsz[i]     = '0;
      assign w_adr0[i]     = '0;
      assign w_am0[i]      = '0;
      assign w_adr1[i]     = '0;
      assign w_am1[i]      = '0;
      assign w_ptr[i]      = '0;
      assign ch_en[i]      = 1'b0;
      assign ch_stop[i]    = 1'b0;
      assign intt[i]       = 1'b0;
      assign w_intt_nxt[i] = 1'b0;
    end
  end

  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_hit[i]) w_rd_sel = w_rdata[i];
    end
  end

  always_comb begin
    sel_csr  = '0;
    sel_txsz = '0;
    sel_adr0 = '0;
    sel_adr1 = '0;
    sel_am0  = '0;
    sel_am1  = '0;
    sel_ptr  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_eng[i]) begin
        sel_csr  = w_csr[i];
        sel_txsz = w_txsz[i];
        sel_adr0 = w_adr0[i];
        sel_adr1 = w_adr1[i];
        sel_am0  = w_am0[i];
        sel_am1  = w_am1[i];
        sel_ptr  = w_ptr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
      r_inta <= 1'b0;
    end else begin
      if (wb_rf_re) r_dout <= w_rd_sel;
      r_inta <= |w_intt_nxt;
    end
  end

  assign wb_rf_dout = r_dout;
  assign inta       = r_inta;

endmodule

// File: tb/tb_wb_dma_ch_rf_bank.sv
// Bench for wb_dma_ch_rf_bank: vector table, directed corner sequences, and
// random traffic checked every cycle against a behavioural channel model.
module tb_wb_dma_ch_rf_bank;

  localparam int NCH = 8;
  localparam int TW  = 12;
  localparam logic [NCH-1:0] PRES = 8'hFE;

  logic          clk = 1'b0;
  logic          rst, wb_rf_we, wb_rf_re;
  logic [7:0]    wb_rf_adr;
  logic [31:0]   wb_rf_din, wb_rf_dout;
  logic [4:0]    ch_sel;
  logic          de_csr_we, de_txsz_we, de_adr0_we, de_adr1_we;
  logic [TW-1:0] de_txsz;
  logic [31:0]   de_adr0, de_adr1;
  logic          dma_done, dma_err, chunk_done;
  logic [31:0]   sel_csr, sel_txsz, sel_adr0, sel_adr1, sel_am0, sel_am1, sel_ptr;
  logic [NCH-1:0] ch_en, ch_stop, intt;
  logic          inta;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_dma_ch_rf_bank #(.NUM_CH(NCH), .TXSZ_W(TW), .CH_PRESENT(PRES)) dut (
    .clk(clk), .rst(rst), .wb_rf_adr(wb_rf_adr), .wb_rf_din(wb_rf_din),
    .wb_rf_we(wb_rf_we), .wb_rf_re(wb_rf_re), .wb_rf_dout(wb_rf_dout),
    .ch_sel(ch_sel), .de_csr_we(de_csr_we), .de_txsz_we(de_txsz_we),
    .de_adr0_we(de_adr0_we), .de_adr1_we(de_adr1_we), .de_txsz(de_txsz),
    .de_adr0(de_adr0), .de_adr1(de_adr1), .dma_done(dma_done), .dma_err(dma_err),
    .chunk_done(chunk_done), .sel_csr(sel_csr), .sel_txsz(sel_txsz),
    .sel_adr0(sel_adr0), .sel_adr1(sel_adr1), .sel_am0(sel_am0), .sel_am1(sel_am1),
    .sel_ptr(sel_ptr), .ch_en(ch_en), .ch_stop(ch_stop), .intt(intt), .inta(inta)
  );

  // Behavioural model: per-channel status flags plus an offset-indexed register array
  bit          m_en[NCH], m_ars[NCH], m_busy[NCH], m_done[NCH], m_err[NCH];
  logic [2:0]  m_mask[NCH], m_src[NCH];
  logic [31:0] m_reg[NCH][8], m_shd[NCH][8];
  logic [31:0] m_dout;
  logic [NCH-1:0] m_stop;

  function automatic bit present(input int c);
    if (c >= NCH) return 1'b0;
    return PRES[3'(c)];
  endfunction

  function automatic logic [31:0] csr_word(input int c);
    return 32'(m_en[c]) | (32'(m_ars[c]) << 1) | (32'(m_busy[c]) << 11) |
           (32'(m_done[c]) << 12) | (32'(m_err[c]) << 13) |
           (32'(m_mask[c]) << 17) | (32'(m_src[c]) << 20);
  endfunction

  function automatic logic [31:0] read_word(input int c, input int o);
    return (o == 0) ? csr_word(c) : m_reg[c][o];
  endfunction

  task automatic model_step();
    int hc, ho, sc;
    bit hv, sv, old_ars;
    logic [31:0] s1, s2, s4;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 0; m_ars[c] = 0; m_busy[c] = 0; m_done[c] = 0; m_err[c] = 0;
        m_mask[c] = '0; m_src[c] = '0;
        for (int o = 0; o < 8; o++) begin m_reg[c][o] = '0; m_shd[c][o] = '0; end
      end
      m_dout = '0;
      m_stop = '0;
      return;
    end
    hc = int'(wb_rf_adr[7:3]); ho = int'(wb_rf_adr[2:0]); sc = int'(ch_sel);
    hv = present(hc); sv = present(sc);
    if (wb_rf_re) m_dout = hv ? read_word(hc, ho) : 32'h0;
    m_stop = '0;
    old_ars = 0; s1 = '0; s2 = '0; s4 = '0;
    if (sv) begin
      old_ars = m_ars[sc]; s1 = m_shd[sc][1]; s2 = m_shd[sc][2]; s4 = m_shd[sc][4];
    end
    if (wb_rf_we && hv) begin
      if (ho == 0) begin
        m_en[hc] = wb_rf_din[0]; m_ars[hc] = wb_rf_din[1]; m_mask[hc] = wb_rf_din[19:17];
        if (wb_rf_din[0]) begin m_busy[hc] = 1; m_done[hc] = 0; m_err[hc] = 0; end
        if (wb_rf_din[14]) m_stop[hc] = 1'b1;
      end else begin
        m_reg[hc][ho] = (ho == 1) ? (wb_rf_din & 32'h0000_0FFF) : wb_rf_din;
        if (ho == 1 || ho == 2 || ho == 4) m_shd[hc][ho] = m_reg[hc][ho];
      end
    end
    if (wb_rf_re && hv && ho == 0) m_src[hc] = '0;
    if (sv) begin
      if (de_csr_we)  m_busy[sc] = 1;
      if (de_txsz_we) m_reg[sc][1] = 32'(de_txsz);
      if (de_adr0_we) m_reg[sc][2] = de_adr0;
      if (de_adr1_we) m_reg[sc][4] = de_adr1;
      if (dma_done) begin
        m_busy[sc] = 0; m_done[sc] = 1; m_src[sc][1] = 1'b1;
        if (old_ars) begin m_reg[sc][1] = s1; m_reg[sc][2] = s2; m_reg[sc][4] = s4; end
        else m_en[sc] = 0;
      end
      if (dma_err) begin m_busy[sc] = 0; m_err[sc] = 1; m_en[sc] = 0; m_src[sc][0] = 1'b1; end
      if (chunk_done) m_src[sc][2] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%08h exp=%08h", nm, act, exp);
    end
  endtask

  task automatic model_compare();
    logic [NCH-1:0] e_en, e_intt;
    int sc;
    bit sv;
    for (int c = 0; c < NCH; c++) begin
      e_en[c]   = m_en[c];
      e_intt[c] = |(m_src[c] & m_mask[c]);
    end
    sc = int'(ch_sel); sv = present(sc);
    chk("m_dout", wb_rf_dout, m_dout);
    chk("m_ch_en", 32'(ch_en), 32'(e_en));
    chk("m_ch_stop", 32'(ch_stop), 32'(m_stop));
    chk("m_intt", 32'(intt), 32'(e_intt));
    chk("m_inta", 32'(inta), 32'(|e_intt));
    chk("m_sel_csr", sel_csr, sv ? csr_word(sc) : 32'h0);
    chk("m_sel_txsz", sel_txsz, sv ? m_reg[sc][1] : 32'h0);
    chk("m_sel_adr0", sel_adr0, sv ? m_reg[sc][2] : 32'h0);
    chk("m_sel_adr1", sel_adr1, sv ? m_reg[sc][4] : 32'h0);
    chk("m_sel_am0", sel_am0, sv ? m_reg[sc][3] : 32'h0);
    chk("m_sel_am1", sel_am1, sv ? m_reg[sc][5] : 32'h0);
    chk("m_sel_ptr", sel_ptr, sv ? m_reg[sc][6] : 32'h0);
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_compare();
    wb_rf_we = 0; wb_rf_re = 0;
    de_csr_we = 0; de_txsz_we = 0; de_adr0_we = 0; de_adr1_we = 0;
    dma_done = 0; dma_err = 0; chunk_done = 0;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    wb_rf_we = 1; wb_rf_adr = a; wb_rf_din = d;
    tick();
  endtask

  task automatic host_rd(input logic [7:0] a);
    wb_rf_re = 1; wb_rf_adr = a;
    tick();
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [7:0]  adr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic re, input logic [7:0] adr,
                              input logic [31:0] din, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.re = re; v.adr = adr; v.din = din; v.exp = exp;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hcr;
    rst = 1; wb_rf_we = 0; wb_rf_re = 0; wb_rf_adr = '0; wb_rf_din = '0; ch_sel = '0;
    de_csr_we = 0; de_txsz_we = 0; de_adr0_we = 0; de_adr1_we = 0;
    de_txsz = '0; de_adr0 = '0; de_adr1 = '0;
    dma_done = 0; dma_err = 0; chunk_done = 0;
    #2;
    tick(); tick();
    rst = 0;
    chk("rst_intt", 32'(intt), 32'h0);
    chk("rst_dout", wb_rf_dout, 32'h0);

    for (int o = 0; o < 8; o++) tbl.push_back(mk(0, 1, 8'(o), 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, 8'h09, 32'h0001_2345, 32'h0));
    tbl.push_back(mk(0, 1, 8'h09, 32'h0, 32'h0000_0345));
    tbl.push_back(mk(1, 0, 8'h08, 32'hFFFF_FFFF, 32'h0));
    tbl.push_back(mk(0, 1, 8'h08, 32'h0, 32'h000E_0803));
    tbl.push_back(mk(1, 0, 8'h0D, 32'hA5A5_5A5A, 32'h0));
    tbl.push_back(mk(0, 1, 8'h0D, 32'h0, 32'hA5A5_5A5A));
    tbl.push_back(mk(1, 0, 8'h0F, 32'h1234_5678, 32'h0));
    tbl.push_back(mk(0, 1, 8'h0F, 32'h0, 32'h1234_5678));
    tbl.push_back(mk(1, 0, 8'h0E, 32'hDEAD_BEEF, 32'h0));
    tbl.push_back(mk(0, 1, 8'h0E, 32'h0, 32'hDEAD_BEEF));
    for (int k = 0; k < tbl.size(); k++) begin
      wb_rf_we = tbl[k].we; wb_rf_re = tbl[k].re;
      wb_rf_adr = tbl[k].adr; wb_rf_din = tbl[k].din;
      tick();
      if (tbl[k].re) chk($sformatf("tbl%0d", k), wb_rf_dout, tbl[k].exp);
    end

    // ADR0 write visible on sel_adr0 next cycle, read back at latency 1
    ch_sel = 5'd3;
    host_wr(8'h1A, 32'h1000_0000);
    chk("adr0_sel", sel_adr0, 32'h1000_0000);
    host_rd(8'h1A);
    chk("adr0_rd", wb_rf_dout, 32'h1000_0000);

    // Done interrupt, then read-clear of the source
    ch_sel = 5'd2;
    host_wr(8'h10, 32'h0004_0001);
    dma_done = 1; tick();
    chk("done_intt2", 32'(intt[2]), 32'h1);
    chk("done_inta", 32'(inta), 32'h1);
    host_rd(8'h10);
    chk("done_csr", wb_rf_dout, 32'h0024_1000);
    chk("done_intt_clr", 32'(intt[2]), 32'h0);
    host_rd(8'h10);
    chk("done_csr2", wb_rf_dout, 32'h0004_1000);

    // Auto-restart reloads TXSZ from the shadow, EN stays set
    ch_sel = 5'd4;
    host_wr(8'h21, 32'h0000_0040);
    host_wr(8'h20, 32'h0000_0003);
    de_txsz_we = 1; de_txsz = '0; tick();
    chk("ars_eng_txsz", sel_txsz, 32'h0);
    dma_done = 1; tick();
    chk("ars_reload", sel_txsz, 32'h0000_0040);
    chk("ars_en", 32'(ch_en[4]), 32'h1);
    host_rd(8'h21);
    chk("ars_rd", wb_rf_dout, 32'h0000_0040);

    // Host/engine collision: engine wins, shadow keeps host data
    ch_sel = 5'd5;
    wb_rf_we = 1; wb_rf_adr = 8'h29; wb_rf_din = 32'h111;
    de_txsz_we = 1; de_txsz = 12'h222; tick();
    chk("coll_live", sel_txsz, 32'h222);
    host_wr(8'h28, 32'h0000_0003);
    dma_done = 1; tick();
    chk("coll_shadow", sel_txsz, 32'h111);

    // Channel index 31 is outside the bank
    host_wr(8'hF8, 32'hFFFF_FFFF);
    host_rd(8'hF8);
    chk("ch31_rd", wb_rf_dout, 32'h0);

    // Absent channel 0 ignores the enable
    host_wr(8'h00, 32'h0000_0001);
    chk("absent_en", 32'(ch_en[0]), 32'h0);
    host_rd(8'h00);
    chk("absent_rd", wb_rf_dout, 32'h0);

    // STOP gives exactly one pulse and reads back 0
    host_wr(8'h30, 32'h0000_4000);
    chk("stop_pulse", 32'(ch_stop), 32'h40);
    tick();
    chk("stop_end", 32'(ch_stop), 32'h0);
    host_rd(8'h30);
    chk("stop_rd", wb_rf_dout, 32'h0);

    // Done and error together: error wins, both sources set
    ch_sel = 5'd7;
    host_wr(8'h38, 32'h0006_0003);
    dma_done = 1; dma_err = 1; tick();
    chk("de_en", 32'(ch_en[7]), 32'h0);
    host_rd(8'h38);
    chk("de_csr", wb_rf_dout, 32'h0036_3002);

    // Source set in the same cycle as read-clear survives
    chunk_done = 1; wb_rf_re = 1; wb_rf_adr = 8'h38; tick();
    chk("rc_pre", wb_rf_dout, 32'h0006_3002);
    host_rd(8'h38);
    chk("rc_post", wb_rf_dout, 32'h0046_3002);

    // Reset mid-transfer swallows the completion
    ch_sel = 5'd2;
    host_wr(8'h10, 32'h0004_0001);
    rst = 1; dma_done = 1; tick();
    rst = 0;
    chk("rst_mid_intt", 32'(intt), 32'h0);
    chk("rst_mid_en", 32'(ch_en), 32'h0);
    host_rd(8'h10);
    chk("rst_mid_rd", wb_rf_dout, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 799) == 0);
      wb_rf_we = ($urandom_range(0, 3) == 0);
      wb_rf_re = ($urandom_range(0, 2) == 0);
      hcr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 31)) : int'($urandom_range(0, 7));
      wb_rf_adr = {5'(hcr), 3'($urandom_range(0, 7))};
      wb_rf_din = $urandom;
      ch_sel = 5'($urandom_range(0, 9));
      de_csr_we = ($urandom_range(0, 5) == 0);
      de_txsz_we = ($urandom_range(0, 5) == 0);
      de_adr0_we = ($urandom_range(0, 5) == 0);
      de_adr1_we = ($urandom_range(0, 5) == 0);
      de_txsz = TW'($urandom);
      de_adr0 = $urandom;
      de_adr1 = $urandom;
      dma_done = ($urandom_range(0, 11) == 0);
      dma_err = ($urandom_range(0, 24) == 0);
      chunk_done = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
